// File: rtl/req_pkg.sv
// Shared definitions for the request front-end and the 4-to-2 priority encoder.
package req_pkg;

  // Number of request lines; must match the encoder input width.
  localparam int N_REQ = 4;

  // Width of the acknowledge index; equals clog2(N_REQ).
  localparam int IDX_W = 2;

  // Default number of stable synchronised cycles before a level change is accepted.
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;

  // One-hot clear mask for an acknowledge; an index with no matching line yields an empty mask.
  function automatic req_vec_t ack_decode(input logic en, input idx_t idx);
    req_vec_t mask;
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = en && (idx == idx_t'(i));
    end
    return mask;
  endfunction

endpackage : req_pkg

// File: rtl/debounce_cell.sv
// One request line: two-flop synchroniser, stability counter and debounced level.
// rise is combinational and is high exactly on the edge where db goes 0 -> 1.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_r;
  logic             s2_r;
  logic             db_r;
  logic [CNT_W-1:0] cnt_r;
  logic             differ_s;
  logic             at_last_s;

  // Two-flop synchroniser; only s2 is used beyond this point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= raw;
      s2_r <= s1_r;
    end
  end

  // Decode whether the synchronised level disagrees with db and whether this is the accepting cycle.
  always_comb begin
    differ_s  = s2_r ^ db_r;
    at_last_s = (cnt_r == CNT_LAST);
  end

  // Count consecutive disagreeing cycles; any return to db restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_r  <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else if (!differ_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (at_last_s) begin
      db_r  <= s2_r;
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign db   = db_r;
  assign rise = differ_s & at_last_s & s2_r;

endmodule : debounce_cell

// File: rtl/req_pending_unit_chk.sv
// Invariant checks for the request front-end, bound into the top level.
module req_pending_unit_chk
  import req_pkg::*;
(
  input logic     clk,
  input logic     rst_n,
  input req_vec_t db,
  input req_vec_t rise,
  input req_vec_t pend,
  input logic     pend_any
);

  // A rise must leave the line debounced high and pending after the same edge.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_line
    a_rise_db : assert property (@(posedge clk) disable iff (!rst_n) rise[gi] |=> db[gi]);
    a_rise_pend : assert property (@(posedge clk) disable iff (!rst_n) rise[gi] |=> pend[gi]);
  end

  // The summary flag always tracks the pending vector.
  a_any : assert property (@(posedge clk) disable iff (!rst_n) pend_any == (|pend));

endmodule : req_pending_unit_chk

// File: rtl/req_pending_unit.sv
// Request front-end for the priority encoder: debounces raw lines, latches each
// debounced press as a sticky pending bit, and flags presses that arrive while
// the same line is still pending.
module req_pending_unit
  import req_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_raw,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             clr_ovr,
  output logic [N_REQ-1:0] pend,
  output logic             pend_any,
  output logic [N_REQ-1:0] ovr
);

  req_vec_t db_s;
  req_vec_t rise_s;
  req_vec_t clr_s;
  req_vec_t ovr_set_s;
  req_vec_t pend_nxt_s;
  req_vec_t ovr_nxt_s;
  req_vec_t pend_r;
  req_vec_t ovr_r;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (req_raw[gi]),
      .db   (db_s[gi]),
      .rise (rise_s[gi])
    );
  end

  // Next pending/overrun state: a new event beats a clear, and an overrun only
  // counts when the old event is not being serviced on the same edge.
  always_comb begin
    clr_s      = ack_decode(ack, ack_idx);
    pend_nxt_s = (pend_r & ~clr_s) | rise_s;
    ovr_set_s  = rise_s & pend_r & ~clr_s;
    if (clr_ovr) begin
      ovr_nxt_s = ovr_set_s;
    end else begin
      ovr_nxt_s = ovr_r | ovr_set_s;
    end
  end

  // Pending and overrun registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= {N_REQ{1'b0}};
      ovr_r  <= {N_REQ{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
      ovr_r  <= ovr_nxt_s;
    end
  end

  assign pend     = pend_r;
  assign ovr      = ovr_r;
  assign pend_any = |pend_r;

  req_pending_unit_chk u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .db      (db_s),
    .rise    (rise_s),
    .pend    (pend_r),
    .pend_any(pend_any)
  );

endmodule : req_pending_unit
